// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_arbiter
// Description : Shares one single-port on-chip RAM (2**ADDR_W x DATA_W) between
//               two Avalon-MM masters (m0 = CPU data, m1 = DMA/pixel).
//               Arbitration is round-robin or fixed-priority, and at most one
//               command per clock is issued to the RAM. Reads are pipelined,
//               and each readdatavalid goes to the master that issued the read.
// Ports       : clk, reset_n             clock, async active-low reset
//               mN_address/byteenable/read/write/writedata   master N command
//               mN_waitrequest           1 = command not accepted this cycle
//               mN_readdata/readdatavalid read return to master N
//               mem_address/byteenable/chipselect/write/writedata/clken
//                                        command to the RAM s1 port
//               mem_readdata             RAM q_a
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_arbiter #(
  parameter int  ADDR_W     = 16,
  parameter int  DATA_W     = 32,
  parameter int  FIXED_PRIO = 0,
  parameter int  RD_LAT     = 1,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  // master 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // RAM port
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam bit c_fixed_prio = (FIXED_PRIO != 0);

  logic              w_req0;
  logic              w_req1;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_rd_accept;
  logic              r_last_grant;       // id of the most recently granted master
  logic [RD_LAT-1:0] r_pipe_valid;
  logic [RD_LAT-1:0] r_pipe_id;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // Grant is purely combinational so the winner's command reaches the RAM in
  // the cycle it is presented. It is gated by reset_n so that both masters
  // see waitrequest=1 and nothing is issued while reset is held.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (reset_n) begin
      if (w_req0 && w_req1) begin
        // On a tie, round-robin favours the master that did not win last.
        if (c_fixed_prio || r_last_grant) begin
          w_grant0 = 1'b1;
        end else begin
          w_grant1 = 1'b1;
        end
      end else begin
        w_grant0 = w_req0;
        w_grant1 = w_req1;
      end
    end
  end

  // Every master that is not granted waits, including masters with no request.
  assign m0_waitrequest = ~w_grant0;
  assign m1_waitrequest = ~w_grant1;

  // The command mux defaults to m0 when nothing is granted. Chipselect
  // qualifies the command, so the address and data are don't-care then.
  assign mem_address    = w_grant1 ? m1_address    : m0_address;
  assign mem_byteenable = w_grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_grant1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = w_grant0 | w_grant1;
  assign mem_write      = (w_grant0 & m0_write) | (w_grant1 & m1_write);
  assign mem_clken      = 1'b1;

  // When read and write are asserted together, the write wins, so the read
  // is not tracked.
  assign w_rd_accept = (w_grant0 & m0_read & ~m0_write) |
                       (w_grant1 & m1_read & ~m1_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
    end else if (mem_chipselect) begin
      r_last_grant <= w_grant1;
    end
  end

  // Read-return tracker: one {valid,id} entry per RAM latency stage. A read
  // accepted at a clock edge is shifted out exactly RD_LAT clocks later, when
  // the RAM presents its data on mem_readdata.
  if (RD_LAT == 1) begin : g_pipe_single
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pipe_valid <= '0;
        r_pipe_id    <= '0;
      end else begin
        r_pipe_valid <= w_rd_accept;
        r_pipe_id    <= w_grant1;
      end
    end
  end else begin : g_pipe_multi
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pipe_valid <= '0;
        r_pipe_id    <= '0;
      end else begin
        r_pipe_valid <= {r_pipe_valid[RD_LAT-2:0], w_rd_accept};
        r_pipe_id    <= {r_pipe_id[RD_LAT-2:0], w_grant1};
      end
    end
  end

  // Both masters see the RAM data, and only readdatavalid qualifies it.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = r_pipe_valid[RD_LAT-1] & ~r_pipe_id[RD_LAT-1];
  assign m1_readdatavalid = r_pipe_valid[RD_LAT-1] &  r_pipe_id[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_onchip_mem_arbiter
// Description : Self-checking bench for onchip_mem_arbiter. A round-robin
//               instance is attached to a behavioural RAM, and a fixed-priority
//               instance is used for the priority scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // round-robin instance
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;

  // fixed-priority instance
  logic [ADDR_W-1:0] f0_address, f1_address;
  logic [BE_W-1:0]   f0_byteenable, f1_byteenable;
  logic              f0_read, f0_write, f1_read, f1_write;
  logic [DATA_W-1:0] f0_writedata, f1_writedata;
  logic              f0_waitrequest, f1_waitrequest;
  logic [DATA_W-1:0] f0_readdata, f1_readdata;
  logic              f0_readdatavalid, f1_readdatavalid;
  logic [ADDR_W-1:0] f_mem_address;
  logic [BE_W-1:0]   f_mem_byteenable;
  logic              f_mem_chipselect, f_mem_write, f_mem_clken;
  logic [DATA_W-1:0] f_mem_writedata, f_mem_readdata;

  int n_pass  = 0;
  int n_total = 0;
  int ref_last;                       // expected last-granted id, RR instance

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(0), .RD_LAT(RD_LAT)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(1), .RD_LAT(RD_LAT)) u_fix (
    .clk(clk), .reset_n(reset_n),
    .m0_address(f0_address), .m0_byteenable(f0_byteenable), .m0_read(f0_read),
    .m0_write(f0_write), .m0_writedata(f0_writedata), .m0_waitrequest(f0_waitrequest),
    .m0_readdata(f0_readdata), .m0_readdatavalid(f0_readdatavalid),
    .m1_address(f1_address), .m1_byteenable(f1_byteenable), .m1_read(f1_read),
    .m1_write(f1_write), .m1_writedata(f1_writedata), .m1_waitrequest(f1_waitrequest),
    .m1_readdata(f1_readdata), .m1_readdatavalid(f1_readdatavalid),
    .mem_address(f_mem_address), .mem_byteenable(f_mem_byteenable),
    .mem_chipselect(f_mem_chipselect), .mem_write(f_mem_write),
    .mem_writedata(f_mem_writedata), .mem_clken(f_mem_clken), .mem_readdata(f_mem_readdata)
  );

  // ---------------- behavioural RAM (environment) ----------------
  function automatic logic [31:0] init_val(input logic [15:0] a);
    return {~a, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  logic [31:0] tb_ram [0:65535];
  bit          tb_wr  [0:65535];
  logic [31:0] rd_pipe [0:RD_LAT-1];

  function automatic logic [31:0] ram_rd(input logic [15:0] a);
    return tb_wr[a] ? tb_ram[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      tb_ram[mem_address] <= merge(ram_rd(mem_address), mem_writedata, mem_byteenable);
      tb_wr[mem_address]  <= 1'b1;
    end
    rd_pipe[0] <= ram_rd(mem_address);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_readdata = rd_pipe[RD_LAT-1];

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  // ---------------- tests ----------------
  task automatic test_reset();
    m0_read = 1'b1; m1_write = 1'b1; f0_read = 1'b1; f1_read = 1'b1;
    @(negedge clk);
    n_total++; if (m0_waitrequest !== 1'b1) $display("FAIL reset m0_waitrequest got %b exp 1", m0_waitrequest); else n_pass++;
    n_total++; if (m1_waitrequest !== 1'b1) $display("FAIL reset m1_waitrequest got %b exp 1", m1_waitrequest); else n_pass++;
    n_total++; if (m0_readdatavalid !== 1'b0) $display("FAIL reset m0_readdatavalid got %b exp 0", m0_readdatavalid); else n_pass++;
    n_total++; if (m1_readdatavalid !== 1'b0) $display("FAIL reset m1_readdatavalid got %b exp 0", m1_readdatavalid); else n_pass++;
    n_total++; if (mem_chipselect !== 1'b0) $display("FAIL reset mem_chipselect got %b exp 0", mem_chipselect); else n_pass++;
    n_total++; if (f0_waitrequest !== 1'b1 || f1_waitrequest !== 1'b1)
      $display("FAIL reset fixed waitrequest got %b%b exp 11", f0_waitrequest, f1_waitrequest); else n_pass++;
    m0_read = 1'b0; m1_write = 1'b0; f0_read = 1'b0; f1_read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ref_last = 1;
    @(negedge clk);
    n_total++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1)
      $display("FAIL idle waitrequest got %b%b exp 11", m0_waitrequest, m1_waitrequest); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    m0_write = 1'b1; m0_address = 16'h0010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    @(negedge clk);
    n_total++; if (m0_waitrequest !== 1'b0) $display("FAIL wr m0_waitrequest got %b exp 0", m0_waitrequest); else n_pass++;
    n_total++; if (mem_write !== 1'b1 || mem_address !== 16'h0010)
      $display("FAIL wr mem_write/addr got %b/%h exp 1/0010", mem_write, mem_address); else n_pass++;
    @(posedge clk); #1;
    m0_write = 1'b0; m0_read = 1'b1;
    @(negedge clk);
    n_total++; if (m0_waitrequest !== 1'b0) $display("FAIL rd m0_waitrequest got %b exp 0", m0_waitrequest); else n_pass++;
    n_total++; if (mem_write !== 1'b0 || mem_chipselect !== 1'b1)
      $display("FAIL rd mem_write/cs got %b/%b exp 0/1", mem_write, mem_chipselect); else n_pass++;
    @(posedge clk); #1;
    m0_read = 1'b0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      n_total++; if (m0_readdatavalid !== (k == RD_LAT))
        $display("FAIL wr_rd m0_readdatavalid k=%0d got %b exp %b", k, m0_readdatavalid, k == RD_LAT); else n_pass++;
      n_total++; if (m1_readdatavalid !== 1'b0) $display("FAIL wr_rd m1_readdatavalid k=%0d got %b exp 0", k, m1_readdatavalid); else n_pass++;
      if (k == RD_LAT) begin
        n_total++; if (m0_readdata !== 32'hDEADBEEF) $display("FAIL wr_rd m0_readdata got %h exp deadbeef", m0_readdata); else n_pass++;
      end
      @(posedge clk); #1;
    end
    ref_mem[32'h10] = 32'hDEADBEEF;
    ref_last = 0;
  endtask

  task automatic test_byte_write();
    m1_write = 1'b1; m1_address = 16'h0040; m1_writedata = 32'hAABBCCDD; m1_byteenable = 4'hF;
    @(negedge clk);
    n_total++; if (m1_waitrequest !== 1'b0) $display("FAIL bw full m1_waitrequest got %b exp 0", m1_waitrequest); else n_pass++;
    @(posedge clk); #1;
    m1_writedata = 32'h0000AB00; m1_byteenable = 4'b0010;
    @(negedge clk);
    n_total++; if (m1_waitrequest !== 1'b0 || mem_byteenable !== 4'b0010)
      $display("FAIL bw byte wait/be got %b/%b exp 0/0010", m1_waitrequest, mem_byteenable); else n_pass++;
    @(posedge clk); #1;
    m1_write = 1'b0; m1_read = 1'b1;
    @(negedge clk);
    n_total++; if (m1_waitrequest !== 1'b0) $display("FAIL bw rd m1_waitrequest got %b exp 0", m1_waitrequest); else n_pass++;
    @(posedge clk); #1;
    m1_read = 1'b0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      n_total++; if (m1_readdatavalid !== (k == RD_LAT))
        $display("FAIL bw m1_readdatavalid k=%0d got %b exp %b", k, m1_readdatavalid, k == RD_LAT); else n_pass++;
      n_total++; if (m0_readdatavalid !== 1'b0) $display("FAIL bw m0_readdatavalid k=%0d got %b exp 0", k, m0_readdatavalid); else n_pass++;
      if (k == RD_LAT) begin
        n_total++; if (m1_readdata !== 32'hAABBABDD) $display("FAIL bw m1_readdata got %h exp aabbabdd", m1_readdata); else n_pass++;
      end
      @(posedge clk); #1;
    end
    ref_mem[32'h40] = 32'hAABBABDD;
    ref_last = 1;
  endtask

  task automatic test_fixed_prio();
    f0_read = 1'b1; f0_address = 16'h0001; f1_read = 1'b1; f1_address = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++; if (f0_waitrequest !== 1'b0 || f1_waitrequest !== 1'b1)
        $display("FAIL fixed cyc %0d waitrequest m0/m1 got %b/%b exp 0/1", i, f0_waitrequest, f1_waitrequest); else n_pass++;
      @(posedge clk); #1;
    end
    f0_read = 1'b0;
    @(negedge clk);
    n_total++; if (f1_waitrequest !== 1'b0) $display("FAIL fixed cyc 5 m1_waitrequest got %b exp 0", f1_waitrequest); else n_pass++;
    @(posedge clk); #1;
    f1_read = 1'b0;
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
  endtask

  // Continuous (rand_mode=0: both masters read back-to-back) or random
  // traffic, checked every cycle against the grant rule and a queue of
  // expected read returns computed from a reference memory.
  task automatic test_traffic(input int n_cmds, input bit rand_mode, input string tag);
    bit          act[2], wr[2], rd_too[2];
    logic [15:0] adr[2];
    logic [31:0] dat[2];
    logic [3:0]  be[2];
    int          issued[2];
    int          g, cyc, last_ret;
    bit          e0, e1;
    logic [31:0] ed;
    exp_t        q[$];
    exp_t        e;
    act = '{0, 0}; issued = '{0, 0}; cyc = 0; last_ret = -1;
    while ((issued[0] < n_cmds || issued[1] < n_cmds || q.size() != 0) && cyc < 6 * n_cmds + 20) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && issued[p] < n_cmds) begin
          if (!rand_mode) begin
            act[p] = 1; wr[p] = 0; rd_too[p] = 0;
            adr[p] = 16'(32'h100 * (p + 1) + issued[p]); dat[p] = '0; be[p] = 4'hF;
          end else if ($urandom_range(0, 9) < 6) begin
            act[p] = 1; wr[p] = ($urandom_range(0, 2) == 0);
            rd_too[p] = wr[p] && ($urandom_range(0, 3) == 0);
            adr[p] = 16'(32'h20 + $urandom_range(0, 15)); dat[p] = $urandom; be[p] = 4'($urandom);
          end
        end
      end
      m0_read = act[0] && (!wr[0] || rd_too[0]); m0_write = act[0] && wr[0];
      m0_address = adr[0]; m0_writedata = dat[0]; m0_byteenable = be[0];
      m1_read = act[1] && (!wr[1] || rd_too[1]); m1_write = act[1] && wr[1];
      m1_address = adr[1]; m1_writedata = dat[1]; m1_byteenable = be[1];
      if (act[0] && act[1]) g = (ref_last == 1) ? 0 : 1;
      else if (act[0]) g = 0;
      else if (act[1]) g = 1;
      else g = -1;
      @(negedge clk);
      n_total++; if (m0_waitrequest !== (g != 0))
        $display("FAIL %s cyc %0d m0_waitrequest got %b exp %b", tag, cyc, m0_waitrequest, g != 0); else n_pass++;
      n_total++; if (m1_waitrequest !== (g != 1))
        $display("FAIL %s cyc %0d m1_waitrequest got %b exp %b", tag, cyc, m1_waitrequest, g != 1); else n_pass++;
      n_total++; if (mem_write !== ((g == 0 && wr[0]) || (g == 1 && wr[1])))
        $display("FAIL %s cyc %0d mem_write got %b", tag, cyc, mem_write); else n_pass++;
      e0 = 0; e1 = 0; ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front(); e0 = (e.id == 0); e1 = (e.id == 1); ed = e.data; last_ret = cyc;
      end
      n_total++; if (m0_readdatavalid !== e0)
        $display("FAIL %s cyc %0d m0_readdatavalid got %b exp %b", tag, cyc, m0_readdatavalid, e0); else n_pass++;
      n_total++; if (m1_readdatavalid !== e1)
        $display("FAIL %s cyc %0d m1_readdatavalid got %b exp %b", tag, cyc, m1_readdatavalid, e1); else n_pass++;
      if (e0) begin
        n_total++; if (m0_readdata !== ed) $display("FAIL %s cyc %0d m0_readdata got %h exp %h", tag, cyc, m0_readdata, ed); else n_pass++;
      end
      if (e1) begin
        n_total++; if (m1_readdata !== ed) $display("FAIL %s cyc %0d m1_readdata got %h exp %h", tag, cyc, m1_readdata, ed); else n_pass++;
      end
      @(posedge clk);
      if (g >= 0) begin
        ref_last = g;
        if (wr[g]) ref_mem[int'(adr[g])] = merge(ref_rd(adr[g]), dat[g], be[g]);
        else q.push_back('{id: g, data: ref_rd(adr[g]), due: cyc + RD_LAT});
        act[g] = 0; issued[g]++;
      end
      cyc++;
      #1;
    end
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    n_total++; if (issued[0] != n_cmds || issued[1] != n_cmds || q.size() != 0)
      $display("FAIL %s incomplete issued %0d/%0d pending %0d exp %0d/%0d/0", tag, issued[0], issued[1], q.size(), n_cmds, n_cmds); else n_pass++;
    if (!rand_mode) begin
      n_total++; if (last_ret != 2 * n_cmds - 1 + RD_LAT)
        $display("FAIL %s last return cycle got %0d exp %0d", tag, last_ret, 2 * n_cmds - 1 + RD_LAT); else n_pass++;
    end
  endtask

  task automatic test_reset_midread();
    m1_read = 1'b1; m1_address = 16'h0055;
    @(negedge clk);
    n_total++; if (m1_waitrequest !== 1'b0) $display("FAIL midrst m1_waitrequest got %b exp 0", m1_waitrequest); else n_pass++;
    @(posedge clk); #1;
    m1_read = 1'b0; reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_total++; if (m1_readdatavalid !== 1'b0) $display("FAIL midrst in-reset m1_readdatavalid k=%0d got %b exp 0", k, m1_readdatavalid); else n_pass++;
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    for (int k = 0; k < RD_LAT + 2; k++) begin
      @(negedge clk);
      n_total++; if (m1_readdatavalid !== 1'b0 || m0_readdatavalid !== 1'b0)
        $display("FAIL midrst post-reset rdv k=%0d got %b%b exp 00", k, m0_readdatavalid, m1_readdatavalid); else n_pass++;
      @(posedge clk); #1;
    end
    // last_grant restarts at 1, so m0 wins the first tie
    m0_read = 1'b1; m1_read = 1'b1;
    @(negedge clk);
    n_total++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1)
      $display("FAIL midrst tie waitrequest m0/m1 got %b/%b exp 0/1", m0_waitrequest, m1_waitrequest); else n_pass++;
    @(posedge clk); #1;
    m0_read = 1'b0; m1_read = 1'b0;
    repeat (RD_LAT + 1) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
    f0_address = '0; f0_byteenable = '0; f0_read = 0; f0_write = 0; f0_writedata = '0;
    f1_address = '0; f1_byteenable = '0; f1_read = 0; f1_write = 0; f1_writedata = '0;
    f_mem_readdata = '0;
    ref_last = 1;
    test_reset();
    test_write_read();
    test_byte_write();
    test_fixed_prio();
    test_traffic(100, 1'b0, "rr_stream");
    test_traffic(150, 1'b1, "random");
    test_reset_midread();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
